ahb2apb_bridge: RTL and testbench
=================================

// Module: ahb2apb_bridge
// PURPOSE
// AHB-Lite slave to APB master bridge; upstream feeder of the amba_apb peripheral.
// Converts each single AHB NONSEQ/SEQ transfer into one APB SETUP/ACCESS transaction.
// Inserts AHB wait states until the APB slave returns pready.
// Returns an AHB ERROR response if pready never arrives within TIMEOUT cycles.
// PARAMETERS
// ADDR_W   32  width of haddr/paddr
// DATA_W   32  width of hwdata/hrdata/pwdata/prdata
// TIMEOUT  16  ACCESS cycles allowed with pready=0 before error; 0 = never time out
// TO_W     5   width of wait counter; must satisfy 2**TO_W > TIMEOUT
// PORTS
// pclk       in   1       single clock; AHB and APB share it
// preset     in   1       synchronous, active-low reset
// hsel       in   1       AHB slave select
// haddr      in   ADDR_W  AHB address, address phase
// htrans     in   2       00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
// hwrite     in   1       1 = write, address phase
// hwdata     in   DATA_W  write data, data phase
// hready_in  in   1       AHB bus HREADY
// hreadyout  out  1       bridge ready / wait-state output
// hresp      out  1       0 OKAY, 1 ERROR
// hrdata     out  DATA_W  read data, registered
// psel       out  1       APB select
// penable    out  1       APB enable
// pwrite     out  1       APB direction
// paddr      out  ADDR_W  APB address
// pwdata     out  DATA_W  APB write data
// prdata     in   DATA_W  APB read data
// pready     in   1       APB slave ready
// All APB buses are declared [0:W-1], MSB-first, so they connect directly to amba_apb.
// BEHAVIOUR
// Reset (preset=0 at a pclk edge):
//   - state=IDLE; hreadyout=1; hresp=0; psel=penable=pwrite=0; paddr=pwdata=hrdata=0.
//   - Mid-transfer reset drops psel/penable at that same edge; no AHB response is issued.
// Valid transfer = hsel & hready_in & htrans[1], sampled only in IDLE.
//   - IDLE/BUSY/unselected transfers: no action, zero-wait OKAY.
// FSM, all outputs registered:
//   - IDLE: on valid transfer -> LOAD; latch paddr<=haddr, pwrite<=hwrite, wait counter<=0;
//     hreadyout<=0.
//   - LOAD (AHB data phase): pwdata<=hwdata (writes only; reads hold pwdata); psel<=1 -> SETUP.
//   - SETUP: penable<=1 -> ACCESS.
//   - ACCESS, pready=1: psel<=0, penable<=0; hrdata<=prdata if read; hreadyout<=1 -> IDLE.
//   - ACCESS, pready=0: counter++; on counter==TIMEOUT-1 (TIMEOUT!=0): psel<=0, penable<=0,
//     hresp<=1, hreadyout stays 0 -> ERR1.
//   - ERR1: hresp=1, hreadyout<=1 -> ERR2 (second error cycle).
//   - ERR2: hresp<=0 -> IDLE; a valid transfer sampled here is accepted exactly as in IDLE.
// Latency with pready=1 in the first ACCESS cycle:
//   - 3 wait states (hreadyout low in LOAD, SETUP, ACCESS); data phase ends at 4th edge.
// Back-to-back transfers:
//   - The next address phase coincides with the completion cycle (hreadyout=1).
//   - It is sampled in IDLE and goes straight to LOAD; no idle gap on AHB.
// Bus holds:
//   - hwdata is held by the master while hreadyout=0; the bridge captures it only in LOAD.
//   - paddr/pwrite/pwdata are held stable from SETUP until the next LOAD/IDLE latch.
// Other rules:
//   - hrdata holds its last read value across writes and errors.
//   - Counter saturates and is cleared on entry to LOAD.
//   - Transfer attributes (hsize, hburst, hprot) are not ports; only 32-bit word transfers
//     are supported.
// STRUCTURE
// Shared include ahb_apb_defs.vh:
//   - HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR.
//   - FSM encodings IDLE, LOAD, SETUP, ACCESS, ERR1, ERR2.
// Sub-module apb_wait_timer (TO_W):
//   - Inputs: clear, count-enable. Output: expired at TIMEOUT-1.
//   - Tied off (never expires) when TIMEOUT=0.
// Everything else is the single FSM and its output registers in this module.
// TESTING (bench instantiates the bridge feeding amba_apb; bench drives pready)
// 1 Write 0x60 <- 0xAA, pready=1:
//   -> psel rises the 2nd edge after the address phase, penable on the 3rd;
//      pwdata=0xAA throughout; hreadyout low exactly 3 cycles; hresp=0.
// 2 Read 0x60 after test 1:
//   -> pwrite=0; hrdata=0xAA when hreadyout returns 1.
// 3 Back-to-back write 0x64 <- 0x55 then read 0x64, no idle gap:
//   -> 2nd LOAD follows the 1st completion cycle directly; read returns 0x55.
// 4 Write with pready held 0 for 3 ACCESS cycles:
//   -> penable high 4 cycles; hreadyout low 6 cycles; no error.
// 5 TIMEOUT=4, pready stuck 0:
//   -> psel/penable drop after 4 ACCESS cycles; hresp=1 for 2 cycles,
//      hreadyout 0 then 1; bridge then accepts a new transfer.
// 6 preset=0 during ACCESS:
//   -> at that edge psel=penable=0, hreadyout=1, hresp=0, state IDLE;
//      a following write completes normally.

Source files
------------

// File: rtl/ahb2apb_bridge_pkg.sv
// Shared AHB/APB encodings and bridge FSM states for the AHB-Lite to APB bridge.
package ahb2apb_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_t;

    // Only selected NONSEQ/SEQ beats on a ready bus start an APB transaction.
    function automatic logic is_valid_transfer(
        input logic       sel,
        input logic       ready,
        input logic [1:0] trans
    );
        logic valid;
        valid = 1'b0;
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: valid = sel & ready;
            HTRANS_IDLE, HTRANS_BUSY:  valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/ahb2apb_bridge_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready and flags when the wait budget is used up.
module ahb2apb_bridge_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Saturating so a TIMEOUT of 0 can never wrap into a spurious match.
    always_ff @(posedge pclk) begin
        if (!preset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP/ACCESS per AHB transfer, with
// wait-state insertion and a two-cycle ERROR response when the APB slave never responds.
module ahb2apb_bridge
    import ahb2apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready_in,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [0:ADDR_W-1] paddr,
    output logic [0:DATA_W-1] pwdata,
    input  logic [0:DATA_W-1] prdata,
    input  logic              pready
);

    bridge_state_t     state, state_n;
    logic              hreadyout_n;
    logic              hresp_n;
    logic [DATA_W-1:0] hrdata_n;
    logic              psel_n;
    logic              penable_n;
    logic              pwrite_n;
    logic [0:ADDR_W-1] paddr_n;
    logic [0:DATA_W-1] pwdata_n;

    logic              start;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_expired;

    ahb2apb_bridge_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wait_timer (
        .pclk    (pclk),
        .preset  (preset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign start        = is_valid_transfer(hsel, hready_in, htrans);
    assign timer_clear  = (state_n == ST_LOAD);
    assign timer_enable = (state == ST_ACCESS) && !pready;

    always_comb begin
        state_n     = state;
        hreadyout_n = hreadyout;
        hresp_n     = hresp;
        hrdata_n    = hrdata;
        psel_n      = psel;
        penable_n   = penable;
        pwrite_n    = pwrite;
        paddr_n     = paddr;
        pwdata_n    = pwdata;

        case (state)
            // ERR2 is the second error cycle; the master may already present the next transfer.
            ST_IDLE, ST_ERR2: begin
                hresp_n = HRESP_OKAY;
                if (start) begin
                    state_n     = ST_LOAD;
                    paddr_n     = haddr;
                    pwrite_n    = hwrite;
                    hreadyout_n = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (pwrite) begin
                    pwdata_n = hwdata;
                end
                psel_n  = 1'b1;
                state_n = ST_SETUP;
            end
            ST_SETUP: begin
                penable_n = 1'b1;
                state_n   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    hreadyout_n = 1'b1;
                    if (!pwrite) begin
                        hrdata_n = prdata;
                    end
                    state_n = ST_IDLE;
                end else if (timer_expired) begin
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    hresp_n   = HRESP_ERROR;
                    state_n   = ST_ERR1;
                end
            end
            ST_ERR1: begin
                hreadyout_n = 1'b1;
                state_n     = ST_ERR2;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!preset) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            hrdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            state     <= state_n;
            hreadyout <= hreadyout_n;
            hresp     <= hresp_n;
            hrdata    <= hrdata_n;
            psel      <= psel_n;
            penable   <= penable_n;
            pwrite    <= pwrite_n;
            paddr     <= paddr_n;
            pwdata    <= pwdata_n;
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: transaction-level reference model plus a behavioural APB slave.
module tb_ahb2apb_bridge;
    import ahb2apb_bridge_pkg::*;

    localparam int TIMEOUT = 4;

    logic        pclk;
    logic        preset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [0:31] paddr;
    logic [0:31] pwdata;
    logic [0:31] prdata;
    logic        pready;

    int total = 0;
    int bad   = 0;

    logic [31:0] slaveMem [logic [31:0]];
    logic [31:0] refMem   [logic [31:0]];
    logic [31:0] lastRead = 32'h0;

    int          plannedWaits = 0;
    int          accessCnt    = 0;
    bit          capValid     = 0;
    logic [31:0] capAddr      = 32'h0;
    logic        capWrite     = 1'b0;
    logic [31:0] capWdata     = 32'h0;

    ahb2apb_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT),
        .TO_W    (3)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hready_in (hready_in),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [31:0] defaultData(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // APB slave: holds pready low for plannedWaits ACCESS cycles, then completes.
    always @(posedge pclk) begin
        #2;
        if (psel && penable) begin
            if (accessCnt >= plannedWaits) begin
                pready   = 1'b1;
                capValid = 1'b1;
                capAddr  = paddr;
                capWrite = pwrite;
                capWdata = pwdata;
                if (pwrite)
                    slaveMem[capAddr] = capWdata;
                else
                    prdata = slaveMem.exists(capAddr) ? slaveMem[capAddr] : defaultData(capAddr);
            end else begin
                pready = 1'b0;
            end
            accessCnt++;
        end else begin
            pready    = 1'b0;
            accessCnt = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge pclk);
        #1;
    endtask

    // One AHB transfer; expectations come from the wait count and the word-memory model.
    task automatic applyStimulus(input logic [31:0] addr, input bit wr, input logic [31:0] data,
                                 input int waits, input bit idleAfter);
        int          cyc;
        int          lowCnt;
        int          penCnt;
        int          respCnt;
        int          pselAt;
        int          penAt;
        bit          done;
        bit          okExp;
        logic [31:0] expRead;

        okExp = (waits < TIMEOUT);
        hsel = 1'b1;
        hready_in = 1'b1;
        htrans = ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        haddr = addr;
        hwrite = wr;
        hwdata = $urandom;
        plannedWaits = waits;
        capValid = 0;

        cyc = 0; lowCnt = 0; penCnt = 0; respCnt = 0; pselAt = -1; penAt = -1; done = 0;
        while (!done && cyc < 40) begin
            stepCycle();
            if (cyc == 0) begin
                hsel = 1'b0;
                htrans = HTRANS_IDLE;
                haddr = $urandom;
                hwrite = $urandom_range(0, 1);
                hwdata = data;
            end
            if (psel && pselAt < 0) pselAt = cyc;
            if (penable && penAt < 0) penAt = cyc;
            if (penable) penCnt++;
            if (hresp) respCnt++;
            if (hreadyout) done = 1;
            else lowCnt++;
            cyc++;
        end
        checkOutput("xfer_done", 32'(done), 32'd1);
        checkOutput("wait_states", lowCnt, okExp ? 3 + waits : TIMEOUT + 3);
        checkOutput("psel_rise", pselAt, 1);
        checkOutput("penable_rise", penAt, 2);
        checkOutput("penable_cycles", penCnt, okExp ? waits + 1 : TIMEOUT);
        checkOutput("hresp_cycles", respCnt, okExp ? 0 : 2);
        checkOutput("psel_end", 32'(psel), 32'd0);

        if (okExp) begin
            checkOutput("apb_seen", 32'(capValid), 32'd1);
            checkOutput("apb_addr", capAddr, addr);
            checkOutput("apb_dir", 32'(capWrite), 32'(wr));
            if (wr) begin
                checkOutput("apb_wdata", capWdata, data);
                refMem[addr] = data;
            end else begin
                expRead = refMem.exists(addr) ? refMem[addr] : defaultData(addr);
                lastRead = expRead;
            end
        end
        checkOutput("hrdata", hrdata, lastRead);

        if (idleAfter) begin
            stepCycle();
            checkOutput("idle_ready", {31'd0, hreadyout}, 32'd1);
            checkOutput("idle_hresp", {31'd0, hresp}, 32'd0);
        end
    endtask

    initial begin
        preset = 1'b0;
        hsel = 1'b0;
        haddr = 32'h0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hwdata = 32'h0;
        hready_in = 1'b1;
        prdata = 32'h0;
        pready = 1'b0;

        repeat (3) stepCycle();
        checkOutput("rst_hreadyout", 32'(hreadyout), 32'd1);
        checkOutput("rst_hresp", 32'(hresp), 32'd0);
        checkOutput("rst_psel_pen", {30'd0, psel, penable}, 32'd0);
        checkOutput("rst_pwrite", 32'(pwrite), 32'd0);
        checkOutput("rst_paddr", paddr, 32'h0);
        checkOutput("rst_pwdata", pwdata, 32'h0);
        checkOutput("rst_hrdata", hrdata, 32'h0);
        preset = 1'b1;
        stepCycle();

        // Unselected, not-ready and IDLE/BUSY beats must never start APB traffic.
        for (int i = 0; i < 6; i++) begin
            haddr = $urandom;
            hwrite = $urandom_range(0, 1);
            case (i % 3)
                0: begin hsel = 1'b0; hready_in = 1'b1; htrans = HTRANS_NONSEQ; end
                1: begin hsel = 1'b1; hready_in = 1'b0; htrans = HTRANS_SEQ; end
                default: begin hsel = 1'b1; hready_in = 1'b1; htrans = (i > 3) ? HTRANS_BUSY : HTRANS_IDLE; end
            endcase
            stepCycle();
            checkOutput("no_action", {30'd0, psel, hreadyout}, 32'd1);
        end
        hsel = 1'b0;
        hready_in = 1'b1;
        htrans = HTRANS_IDLE;
        stepCycle();

        applyStimulus(32'h60, 1'b1, 32'hAA, 0, 1'b1);
        applyStimulus(32'h60, 1'b0, 32'h0, 0, 1'b1);
        applyStimulus(32'h64, 1'b1, 32'h55, 0, 1'b0);
        applyStimulus(32'h64, 1'b0, 32'h0, 0, 1'b1);
        applyStimulus(32'h60, 1'b1, 32'h1234, 3, 1'b1);
        applyStimulus(32'h70, 1'b1, 32'hBEEF, 100, 1'b0);
        applyStimulus(32'h70, 1'b0, 32'h0, 1, 1'b1);
        applyStimulus(32'h60, 1'b0, 32'h0, 2, 1'b1);

        // Reset while the bridge is in ACCESS, then resume normal traffic.
        hsel = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr = 32'h68;
        hwrite = 1'b1;
        plannedWaits = 10;
        stepCycle();
        hsel = 1'b0;
        htrans = HTRANS_IDLE;
        hwdata = 32'h77;
        repeat (2) stepCycle();
        checkOutput("pre_rst_access", {30'd0, psel, penable}, 32'd3);
        preset = 1'b0;
        stepCycle();
        preset = 1'b1;
        checkOutput("midrst_psel_pen", {30'd0, psel, penable}, 32'd0);
        checkOutput("midrst_ready", 32'(hreadyout), 32'd1);
        checkOutput("midrst_hresp", 32'(hresp), 32'd0);
        checkOutput("midrst_paddr", paddr, 32'h0);
        lastRead = 32'h0;
        checkOutput("midrst_hrdata", hrdata, lastRead);
        stepCycle();
        applyStimulus(32'h68, 1'b1, 32'h12, 0, 1'b0);
        applyStimulus(32'h68, 1'b0, 32'h0, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(32'h100 + 32'($urandom_range(0, 7)) * 4, 1'($urandom_range(0, 1)),
                          $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        stepCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
